// File: rtl/rr_mux_arbiter_if.sv
// Bundle of request-side and output-side handshake signals for rr_mux_arbiter.
// The master modport is the environment (producers plus consumer); the slave modport is the arbiter.
interface rr_mux_arbiter_if #(
    parameter int W    = 4,
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
);
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic [SELW-1:0] sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_src;
    logic            out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, sel, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that steers one of N requesters through the mux select
// into a single-entry registered output stage with valid/ready handshake.
module rr_mux_arbiter #(
    parameter int W    = 4,
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input logic             clk,
    input logic             rst_n,
    rr_mux_arbiter_if.slave bus
);
    logic [SELW-1:0] ptr_reg;
    logic [SELW-1:0] ptr_next;
    logic            out_valid_reg;
    logic [W-1:0]    out_data_reg;
    logic [SELW-1:0] out_src_reg;

    logic [SELW-1:0] sel_c;
    logic            any_valid;
    logic            load_en;
    logic            xfer;
    logic [N-1:0]    in_ready_c;
    logic [W-1:0]    data_arr [N];

    // Walk offsets from farthest to nearest so the nearest valid index past ptr wins.
    always_comb begin
        logic [SELW-1:0] idx;
        sel_c = ptr_reg;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr_reg + SELW'(k);
            if (bus.in_valid[idx]) begin
                sel_c = idx;
            end
        end
    end

    assign any_valid = |bus.in_valid;
    assign load_en   = !out_valid_reg || bus.out_ready;
    assign xfer      = rst_n && load_en && any_valid;
    assign ptr_next  = xfer ? sel_c + SELW'(1) : ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign data_arr[gi]   = bus.in_data[gi*W +: W];
            assign in_ready_c[gi] = xfer && (sel_c == SELW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (xfer) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= data_arr[sel_c];
                out_src_reg   <= sel_c;
            end else if (out_valid_reg && bus.out_ready) begin
                // Drained with nothing to replace it: data and source keep their last values.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sel       = sel_c;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_src   = out_src_reg;
endmodule
